pmem_port_arbiter: RTL

- Shares the single-read-port program ROM between two requesters: the instruction-fetch stage and a data-load port used for constant reads from program memory.
- Sits between the core and the ROM. Drives the ROM read address in c0 and routes the ROM's 1-cycle-latency data back to the winner in c1.
- Fetch has fixed priority. A starvation counter forces a load grant after MAX_WAIT lost cycles.

---
 rtl/pmem_port_arbiter_pkg.sv | 27 ++
 rtl/pmem_port_arbiter_if.sv | 42 ++++
 rtl/pmem_port_arbiter_starve_cnt.sv | 42 ++++
 rtl/pmem_port_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/pmem_port_arbiter_pkg.sv
// Shared types and defaults for the program-memory port arbiter.
package pmem_arb_pkg;

    localparam int PMEM_AW_DEF = 10;
    localparam int PMEM_DW_DEF = 32;
    // Wide enough for MAX_WAIT up to 15.
    localparam int WAIT_CNT_W  = 4;

    // Which requester owns the ROM data returning in c1.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2
    } owner_e;

    // Arbitration priority state.
    typedef enum logic [0:0] {
        IF_PRIO = 1'b0,
        LD_PRIO = 1'b1
    } arb_state_e;

    // A load is misaligned when its byte address is not word aligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return |addr_lsb;
    endfunction

endpackage

// File: rtl/pmem_port_arbiter_if.sv
// Bundle of the fetch, load and ROM-side signals around the arbiter.
// The arbiter uses the slave view; the core/ROM environment uses master.
interface pmem_port_arbiter_if #(
    parameter int PMEM_AW = 10,
    parameter int PMEM_DW = 32
);
    // Fetch side
    logic               if_req_c0;
    logic [PMEM_AW-1:0] if_addr_c0;
    logic               if_gnt_c0;
    logic               if_rvalid_c1;
    logic [PMEM_DW-1:0] if_rdata_c1;
    // Load side
    logic               ld_req_c0;
    logic [PMEM_AW-1:0] ld_addr_c0;
    logic               ld_gnt_c0;
    logic               ld_rvalid_c1;
    logic [PMEM_DW-1:0] ld_rdata_c1;
    logic               ld_err_c1;
    // ROM side
    logic [PMEM_AW-1:0] pmem_addr_c0;
    logic [PMEM_DW-1:0] pmem_data_c1;

    modport slave (
        input  if_req_c0, if_addr_c0,
        output if_gnt_c0, if_rvalid_c1, if_rdata_c1,
        input  ld_req_c0, ld_addr_c0,
        output ld_gnt_c0, ld_rvalid_c1, ld_rdata_c1, ld_err_c1,
        output pmem_addr_c0,
        input  pmem_data_c1
    );

    modport master (
        output if_req_c0, if_addr_c0,
        input  if_gnt_c0, if_rvalid_c1, if_rdata_c1,
        output ld_req_c0, ld_addr_c0,
        input  ld_gnt_c0, ld_rvalid_c1, ld_rdata_c1, ld_err_c1,
        input  pmem_addr_c0,
        output pmem_data_c1
    );

endinterface

// File: rtl/pmem_port_arbiter_starve_cnt.sv
// Saturating count of consecutive cycles a pending load has lost arbitration.
// hit_o flags that the count being loaded this cycle equals MAX_WAIT, so the
// arbiter can switch to load priority for the following cycle.
module pmem_starve_cnt
    import pmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);

    localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    // Clear wins over increment; increment stops at MAX_CNT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_CNT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign hit_o = (cnt_d == MAX_CNT);

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pmem_port_arbiter.sv
// Arbiter sharing the single-read-port program ROM between instruction fetch
// and the data-load port. Fetch has fixed priority; a load that keeps losing
// is promoted for one cycle after MAX_WAIT lost cycles. Grants are
// combinational in c0, and ROM data is steered to the c0 winner in c1.
module pmem_port_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int PMEM_AW  = PMEM_AW_DEF,
    parameter int PMEM_DW  = PMEM_DW_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pmem_port_arbiter_if.slave    bus
);

    arb_state_e         state_q;
    arb_state_e         state_d;
    owner_e             owner_c1_q;
    owner_e             owner_c1_d;
    logic               err_c1_q;
    logic               err_c1_d;
    logic [PMEM_AW-1:0] addr_hold_q;
    logic [PMEM_AW-1:0] addr_hold_d;

    logic               force_ld_c0;
    logic               if_gnt_c0;
    logic               ld_gnt_c0;
    logic               starve_hit_c0;
    logic [PMEM_AW-1:0] pmem_addr_c0;
    logic [PMEM_DW-1:0] if_rdata_c1;
    logic [PMEM_DW-1:0] ld_rdata_c1;

    // Grant decision: load overrides fetch only while promoted.
    always_comb begin
        force_ld_c0 = (state_q == LD_PRIO) && bus.ld_req_c0;
        if_gnt_c0   = bus.if_req_c0 && !force_ld_c0;
        ld_gnt_c0   = bus.ld_req_c0 && !if_gnt_c0;
    end

    // A waiting load that loses counts up; a grant or a dropped request clears.
    pmem_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (ld_gnt_c0 || !bus.ld_req_c0),
        .inc_i   (bus.ld_req_c0 && !ld_gnt_c0),
        .hit_o   (starve_hit_c0)
    );

    // Address mux, next priority state and c1 ownership bookkeeping.
    always_comb begin
        if (if_gnt_c0) begin
            pmem_addr_c0 = bus.if_addr_c0;
        end else if (ld_gnt_c0) begin
            pmem_addr_c0 = bus.ld_addr_c0;
        end else begin
            // Park on the last granted address so the ROM bus stays quiet.
            pmem_addr_c0 = addr_hold_q;
        end
        addr_hold_d = pmem_addr_c0;

        owner_c1_d = OWN_NONE;
        if (if_gnt_c0) begin
            owner_c1_d = OWN_IF;
        end else if (ld_gnt_c0) begin
            owner_c1_d = OWN_LD;
        end

        // The ROM ignores the low address bits, so a misaligned load is
        // still read from the aligned word and only flagged here.
        err_c1_d = ld_gnt_c0 && is_misaligned(bus.ld_addr_c0[1:0]);

        // Promotion lasts exactly one cycle, used or not.
        if (state_q == LD_PRIO) begin
            state_d = IF_PRIO;
        end else if (starve_hit_c0) begin
            state_d = LD_PRIO;
        end else begin
            state_d = IF_PRIO;
        end
    end

    // c0 -> c1 registers; reset drops any in-flight response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IF_PRIO;
            owner_c1_q  <= OWN_NONE;
            err_c1_q    <= 1'b0;
            addr_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_c1_q  <= owner_c1_d;
            err_c1_q    <= err_c1_d;
            addr_hold_q <= addr_hold_d;
        end
    end

    // Response steering: only the owner sees ROM data; errored loads read 0.
    always_comb begin
        if_rdata_c1 = '0;
        ld_rdata_c1 = '0;
        if (owner_c1_q == OWN_IF) begin
            if_rdata_c1 = bus.pmem_data_c1;
        end
        if ((owner_c1_q == OWN_LD) && !err_c1_q) begin
            ld_rdata_c1 = bus.pmem_data_c1;
        end
    end

    assign bus.if_gnt_c0    = if_gnt_c0;
    assign bus.ld_gnt_c0    = ld_gnt_c0;
    assign bus.pmem_addr_c0 = pmem_addr_c0;
    assign bus.if_rvalid_c1 = (owner_c1_q == OWN_IF);
    assign bus.ld_rvalid_c1 = (owner_c1_q == OWN_LD);
    assign bus.if_rdata_c1  = if_rdata_c1;
    assign bus.ld_rdata_c1  = ld_rdata_c1;
    assign bus.ld_err_c1    = err_c1_q;

endmodule
